// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned ARB_P0    = 0;
    localparam int unsigned ARB_P1    = 1;
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned DWIDTH  = 32;
    localparam int unsigned BEWIDTH = 4;
    localparam int unsigned WAIT_W  = 8;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_owner_t;

    // Increment that sticks at all-ones.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and SRAM pins of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AWIDTH = 12
) ();
    import dmem_arbiter_pkg::*;

    logic               P0_REQ,    P1_REQ;
    logic               P0_WEN,    P1_WEN;
    logic [BEWIDTH-1:0] P0_BE,     P1_BE;
    logic [AWIDTH-1:0]  P0_ADDR,   P1_ADDR;
    logic [DWIDTH-1:0]  P0_DI,     P1_DI;
    logic               P0_GNT,    P1_GNT;
    logic               P0_RVALID, P1_RVALID;
    logic [DWIDTH-1:0]  P0_DOUT,   P1_DOUT;

    logic               MEM_CSN;
    logic               MEM_WEN;
    logic [BEWIDTH-1:0] MEM_BE;
    logic [AWIDTH-1:0]  MEM_ADDR;
    logic [DWIDTH-1:0]  MEM_DI;
    logic [DWIDTH-1:0]  MEM_DOUT;

    // Requesters and SRAM side.
    modport master (
        output P0_REQ, P1_REQ, P0_WEN, P1_WEN, P0_BE, P1_BE,
               P0_ADDR, P1_ADDR, P0_DI, P1_DI, MEM_DOUT,
        input  P0_GNT, P1_GNT, P0_RVALID, P1_RVALID, P0_DOUT, P1_DOUT,
               MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI
    );

    // Arbiter side.
    modport slave (
        input  P0_REQ, P1_REQ, P0_WEN, P1_WEN, P0_BE, P1_BE,
               P0_ADDR, P1_ADDR, P0_DI, P1_DI, MEM_DOUT,
        output P0_GNT, P1_GNT, P0_RVALID, P1_RVALID, P0_DOUT, P1_DOUT,
               MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI
    );

endinterface

// File: rtl/arb2_pick.sv
// Two-input combinational picker: single requester wins, conflicts go to the
// port that was not granted last unless port 1 is being forced through.
module arb2_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_p1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (force_p1 || !last) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data SRAM between the core data port (0) and a
// debug/DMA loader port (1); reads return one cycle after their grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic           CLK,
    input  logic           RSTn,
    dmem_arbiter_if.slave  bus
);

    logic              last;
    logic [WAIT_W-1:0] wait_cnt;
    rd_owner_t         rd_owner;

    logic [1:0]         req_c;
    logic [1:0]         gnt_c;
    logic               force_p1;
    logic               pick_last;
    logic               rd_fire;
    logic               p0_rvalid;
    logic               p1_rvalid;

    logic               mem_csn;
    logic               mem_wen;
    logic [BEWIDTH-1:0] mem_be;
    logic [AWIDTH-1:0]  mem_addr;
    logic [DWIDTH-1:0]  mem_di;

    // Requests are masked while in reset so no grant or SRAM access can leak out.
    assign req_c     = {bus.P1_REQ, bus.P0_REQ} & {2{RSTn}};
    assign force_p1  = (PRIO_MODE == ARB_FIXED) && (wait_cnt >= WAIT_W'(MAX_WAIT));
    assign pick_last = (PRIO_MODE == ARB_FIXED) ? 1'b1 : last;

    arb2_pick u_pick (
        .req      (req_c),
        .last     (pick_last),
        .force_p1 (force_p1),
        .gnt      (gnt_c)
    );

    // Granted port payload onto the SRAM pins; idle pins otherwise.
    always_comb begin
        mem_csn  = 1'b1;
        mem_wen  = 1'b1;
        mem_be   = '0;
        mem_addr = '0;
        mem_di   = '0;
        if (gnt_c[ARB_P0]) begin
            mem_csn  = 1'b0;
            mem_wen  = bus.P0_WEN;
            mem_be   = bus.P0_BE;
            mem_addr = bus.P0_ADDR;
            mem_di   = bus.P0_DI;
        end else if (gnt_c[ARB_P1]) begin
            mem_csn  = 1'b0;
            mem_wen  = bus.P1_WEN;
            mem_be   = bus.P1_BE;
            mem_addr = bus.P1_ADDR;
            mem_di   = bus.P1_DI;
        end
    end

    assign rd_fire = ~mem_csn & mem_wen;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last     <= 1'b1;
            wait_cnt <= '0;
            rd_owner <= '0;
        end else begin
            if (|gnt_c) begin
                last <= gnt_c[ARB_P1];
            end
            if (bus.P1_REQ && !gnt_c[ARB_P1]) begin
                wait_cnt <= sat_inc(wait_cnt);
            end else begin
                wait_cnt <= '0;
            end
            rd_owner.valid <= rd_fire;
            rd_owner.port  <= gnt_c[ARB_P1];
        end
    end

    assign p0_rvalid = rd_owner.valid && (rd_owner.port == 1'(ARB_P0));
    assign p1_rvalid = rd_owner.valid && (rd_owner.port == 1'(ARB_P1));

    assign bus.P0_GNT    = gnt_c[ARB_P0];
    assign bus.P1_GNT    = gnt_c[ARB_P1];
    assign bus.P0_RVALID = p0_rvalid;
    assign bus.P1_RVALID = p1_rvalid;
    assign bus.P0_DOUT   = p0_rvalid ? bus.MEM_DOUT : '0;
    assign bus.P1_DOUT   = p1_rvalid ? bus.MEM_DOUT : '0;

    assign bus.MEM_CSN  = mem_csn;
    assign bus.MEM_WEN  = mem_wen;
    assign bus.MEM_BE   = mem_be;
    assign bus.MEM_ADDR = mem_addr;
    assign bus.MEM_DI   = mem_di;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority (MAX_WAIT=3)
// instance, each with its own SRAM, checked every cycle against a rule model.
module tb_dmem_arbiter;

    localparam int unsigned AW     = 12;
    localparam int          FX_MAX = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus, indexed [instance][port]; instance 0 = round-robin, 1 = fixed.
    logic          req  [2][2];
    logic          wen  [2][2];
    logic [3:0]    be   [2][2];
    logic [AW-1:0] addr [2][2];
    logic [31:0]   di   [2][2];

    logic [1:0]    gnt   [2];
    logic [1:0]    rv    [2];
    logic [31:0]   dout  [2][2];
    logic          csn   [2];
    logic          mwen  [2];
    logic [3:0]    mbe   [2];
    logic [AW-1:0] maddr [2];
    logic [31:0]   mdi   [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dmem_arbiter_if #(.AWIDTH(AW)) bus ();
        logic [31:0] sram [16];

        assign bus.P0_REQ  = req[k][0];
        assign bus.P1_REQ  = req[k][1];
        assign bus.P0_WEN  = wen[k][0];
        assign bus.P1_WEN  = wen[k][1];
        assign bus.P0_BE   = be[k][0];
        assign bus.P1_BE   = be[k][1];
        assign bus.P0_ADDR = addr[k][0];
        assign bus.P1_ADDR = addr[k][1];
        assign bus.P0_DI   = di[k][0];
        assign bus.P1_DI   = di[k][1];

        assign gnt[k]     = {bus.P1_GNT, bus.P0_GNT};
        assign rv[k]      = {bus.P1_RVALID, bus.P0_RVALID};
        assign dout[k][0] = bus.P0_DOUT;
        assign dout[k][1] = bus.P1_DOUT;
        assign csn[k]     = bus.MEM_CSN;
        assign mwen[k]    = bus.MEM_WEN;
        assign mbe[k]     = bus.MEM_BE;
        assign maddr[k]   = bus.MEM_ADDR;
        assign mdi[k]     = bus.MEM_DI;

        initial for (int i = 0; i < 16; i++) sram[i] = 32'h0;

        // Behavioural single-port SRAM: byte-masked write, registered read.
        always @(posedge clk) begin
            if (!bus.MEM_CSN) begin
                if (!bus.MEM_WEN) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.MEM_BE[b]) sram[bus.MEM_ADDR[5:2]][8*b +: 8] = bus.MEM_DI[8*b +: 8];
                end else begin
                    bus.MEM_DOUT <= sram[bus.MEM_ADDR[5:2]];
                end
            end
        end

        dmem_arbiter #(.AWIDTH(AW), .PRIO_MODE(k), .MAX_WAIT(FX_MAX)) u_dut (
            .CLK  (clk),
            .RSTn (rst_n),
            .bus  (bus.slave)
        );
    end

    // Reference model state.
    bit          m_last [2];
    int          m_wcnt [2];
    bit          m_rv   [2];
    int          m_rvp  [2];
    logic [31:0] m_rvd  [2];
    logic [31:0] m_mem  [2][16];
    int          win    [2];
    bit          pend   [2][2];

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Expected winner from the arbitration rules, then every output compared.
    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int w;
            string s;
            if (!rst_n)                          w = -1;
            else if (req[k][0] && req[k][1]) begin
                if (k == 1) w = (m_wcnt[k] >= FX_MAX) ? 1 : 0;
                else        w = m_last[k] ? 0 : 1;
            end
            else if (req[k][0])                  w = 0;
            else if (req[k][1])                  w = 1;
            else                                 w = -1;
            win[k] = w;
            s = $sformatf("[%0d]", k);
            check({"gnt", s},  32'(gnt[k]), (w < 0) ? 32'd0 : ((w == 0) ? 32'd1 : 32'd2));
            check({"csn", s},  32'(csn[k]),  (w < 0) ? 32'd1 : 32'd0);
            check({"mwen", s}, 32'(mwen[k]), (w < 0) ? 32'd1 : 32'(wen[k][w]));
            check({"mbe", s},  32'(mbe[k]),  (w < 0) ? 32'd0 : 32'(be[k][w]));
            check({"madr", s}, 32'(maddr[k]), (w < 0) ? 32'd0 : 32'(addr[k][w]));
            check({"mdi", s},  mdi[k],        (w < 0) ? 32'd0 : di[k][w]);
            check({"rv", s},   32'(rv[k]), !m_rv[k] ? 32'd0 : ((m_rvp[k] == 0) ? 32'd1 : 32'd2));
            check({"dout0", s}, dout[k][0], (m_rv[k] && m_rvp[k] == 0) ? m_rvd[k] : 32'd0);
            check({"dout1", s}, dout[k][1], (m_rv[k] && m_rvp[k] == 1) ? m_rvd[k] : 32'd0);
        end
    endtask

    task automatic advance_model();
        for (int k = 0; k < 2; k++) begin
            int w = win[k];
            if (!rst_n) begin
                m_last[k] = 1'b1;
                m_wcnt[k] = 0;
                m_rv[k]   = 1'b0;
                continue;
            end
            m_rv[k] = (w >= 0) && wen[k][w];
            if (m_rv[k]) begin
                m_rvp[k] = w;
                m_rvd[k] = m_mem[k][addr[k][w][5:2]];
            end
            if (w >= 0 && !wen[k][w])
                m_mem[k][addr[k][w][5:2]] = merge(m_mem[k][addr[k][w][5:2]], di[k][w], be[k][w]);
            if (w >= 0) m_last[k] = (w == 1);
            m_wcnt[k] = (req[k][1] && w != 1) ? ((m_wcnt[k] < 255) ? m_wcnt[k] + 1 : 255) : 0;
            for (int p = 0; p < 2; p++) pend[k][p] = req[k][p] && (w != p);
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        advance_model();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input bit r, input bit w, input logic [3:0] b,
                         input logic [AW-1:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            req[k][p] = r; wen[k][p] = w; be[k][p] = b; addr[k][p] = a; di[k][p] = d;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b1, 4'h0, '0, '0);
        drive(1, 1'b0, 1'b1, 4'h0, '0, '0);
    endtask

    // Pending requests mostly stay put; otherwise a fresh random request.
    task automatic rand_inputs();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                if (!(pend[k][p] && $urandom_range(0, 7) != 0)) begin
                    req[k][p]  = ($urandom_range(0, 2) != 0);
                    wen[k][p]  = 1'($urandom_range(0, 1));
                    be[k][p]   = 4'($urandom);
                    addr[k][p] = AW'($urandom_range(0, 15) * 4);
                    di[k][p]   = $urandom;
                end
    endtask

    logic [1:0] rr_pat [6];
    logic [1:0] fx_pat [6];

    initial begin
        rr_pat = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        fx_pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1; m_wcnt[k] = 0; m_rv[k] = 1'b0; m_rvp[k] = 0; m_rvd[k] = '0;
            pend[k][0] = 1'b0; pend[k][1] = 1'b0; win[k] = -1;
            for (int i = 0; i < 16; i++) m_mem[k][i] = 32'h0;
        end

        // Reset held with both ports requesting.
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 4'hF, 12'h000, 32'h0);
        drive(1, 1'b1, 1'b1, 4'hF, 12'h004, 32'h0);
        @(negedge clk);
        repeat (3) step();

        // Continuous read conflict from reset.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_alt", 32'(gnt[0]), 32'(rr_pat[i]));
            check("fx_alt", 32'(gnt[1]), 32'(fx_pat[i]));
            step();
        end
        idle();
        repeat (2) step();

        // Port 1 writes, port 0 reads it back.
        drive(1, 1'b1, 1'b0, 4'hF, 12'h010, 32'hDEADBEEF);
        #1; check("wr_gnt", 32'(gnt[0]), 32'd2);
        step();
        idle();
        drive(0, 1'b1, 1'b1, 4'hF, 12'h010, 32'h0);
        #1; check("rd_gnt", 32'(gnt[0]), 32'd1);
        step();
        idle();
        #1;
        check("rd_rv", 32'(rv[0]), 32'd1);
        check("rd_data", dout[0][0], 32'hDEADBEEF);
        step();

        // Partial byte-enable write over a preset word.
        drive(1, 1'b1, 1'b0, 4'hF, 12'h020, 32'hAAAAAAAA);
        step();
        idle();
        drive(0, 1'b1, 1'b0, 4'b0011, 12'h020, 32'h11223344);
        step();
        idle();
        drive(1, 1'b1, 1'b1, 4'hF, 12'h020, 32'h0);
        step();
        idle();
        #1; check("be_data", dout[1][1], 32'hAAAA3344);
        step();

        // Reset lands between a read grant and its return.
        drive(0, 1'b1, 1'b1, 4'hF, 12'h010, 32'h0);
        #1;
        check_outputs();
        #1;
        rst_n = 1'b0;
        advance_model();
        @(negedge clk);
        idle();
        step();
        rst_n = 1'b1;
        #1; check("rst_rv", 32'(rv[0]), 32'd0);
        step();
        drive(0, 1'b1, 1'b1, 4'hF, 12'h000, 32'h0);
        drive(1, 1'b1, 1'b1, 4'hF, 12'h004, 32'h0);
        #1; check("rst_last", 32'(gnt[0]), 32'd1);
        step();
        idle();
        repeat (2) step();

        // Randomized traffic on both instances.
        repeat (800) begin
            rand_inputs();
            step();
        end
        idle();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
